// File: rtl/calendar_pkg.sv
// rtl/calendar_pkg.sv - shared calendar types and month-length helpers
package calendar_pkg;

  localparam logic [3:0] MON_JAN = 4'd1,  MON_FEB = 4'd2,  MON_MAR = 4'd3,  MON_APR = 4'd4;
  localparam logic [3:0] MON_MAY = 4'd5,  MON_JUN = 4'd6,  MON_JUL = 4'd7,  MON_AUG = 4'd8;
  localparam logic [3:0] MON_SEP = 4'd9,  MON_OCT = 4'd10, MON_NOV = 4'd11, MON_DEC = 4'd12;

  typedef enum logic [2:0] {
    WK_MON = 3'd1, WK_TUE = 3'd2, WK_WED = 3'd3, WK_THU = 3'd4,
    WK_FRI = 3'd5, WK_SAT = 3'd6, WK_SUN = 3'd7
  } weekday_t;

  function automatic logic is_leap(input logic [31:0] year);
    return ((year % 32'd4 == 32'd0) && (year % 32'd100 != 32'd0)) || (year % 32'd400 == 32'd0);
  endfunction

  // Out-of-range months report 0 days so any day check against them fails.
  function automatic logic [4:0] days_in_month(input logic [31:0] year, input logic [3:0] mon);
    case (mon)
      MON_FEB:                            return is_leap(year) ? 5'd29 : 5'd28;
      MON_APR, MON_JUN, MON_SEP, MON_NOV: return 5'd30;
      MON_JAN, MON_MAR, MON_MAY, MON_JUL,
      MON_AUG, MON_OCT, MON_DEC:          return 5'd31;
      default:                            return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/calendar_month_len.sv
// rtl/calendar_month_len.sv - combinational days-in-month lookup
module calendar_month_len
  import calendar_pkg::*;
#(
  parameter int YEAR_W = 12
) (
  input  logic [YEAR_W-1:0] year,
  input  logic [3:0]        mon,
  output logic [4:0]        days
);

  assign days = days_in_month(32'(year), mon);

endmodule

// File: rtl/calendar_rtc.sv
// rtl/calendar_rtc.sv - perpetual-calendar RTC with run/hold, validated load and alarm
module calendar_rtc
  import calendar_pkg::*;
#(
  parameter int TICK_DIV   = 10,
  parameter int YEAR_W     = 12,
  parameter int YEAR_MIN   = 2000,
  parameter int YEAR_MAX   = 2199,
  parameter int RESET_YEAR = 2000,
  parameter int RESET_WEEK = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              time_set,
  input  logic [YEAR_W-1:0] year_set,
  input  logic [3:0]        mon_set,
  input  logic [2:0]        week_set,
  input  logic [4:0]        day_set,
  input  logic [4:0]        hour_set,
  input  logic [5:0]        min_set,
  input  logic [5:0]        sec_set,
  input  logic              alarm_en,
  input  logic [4:0]        alarm_hour,
  input  logic [5:0]        alarm_min,
  output logic [YEAR_W-1:0] year,
  output logic [3:0]        mon,
  output logic [2:0]        week,
  output logic [4:0]        day,
  output logic [4:0]        hour,
  output logic [5:0]        min,
  output logic [5:0]        sec,
  output logic              year_carry,
  output logic              mon_carry,
  output logic              day_carry,
  output logic              hour_carry,
  output logic              min_carry,
  output logic              set_err,
  output logic              alarm
);

  localparam int                CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [YEAR_W-1:0] Y_MIN    = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0] Y_MAX    = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W-1:0] Y_RST    = YEAR_W'(RESET_YEAR);
  localparam logic [2:0]        W_RST    = 3'(RESET_WEEK);

  logic [CNT_W-1:0]  cnt;
  logic [4:0]        cur_days, set_days;
  logic              tick, set_ok, alarm_hit;
  logic              c_min, c_hour, c_day, c_mon, c_year;
  logic [YEAR_W-1:0] year_n;
  logic [3:0]        mon_n;
  logic [2:0]        week_n;
  logic [4:0]        day_n, hour_n;
  logic [5:0]        min_n, sec_n;

  calendar_month_len #(.YEAR_W(YEAR_W)) u_cur_len (.year(year),     .mon(mon),     .days(cur_days));
  calendar_month_len #(.YEAR_W(YEAR_W)) u_set_len (.year(year_set), .mon(mon_set), .days(set_days));

  assign tick   = run && (cnt == CNT_LAST);
  assign set_ok = (year_set >= Y_MIN) && (year_set <= Y_MAX)
               && (mon_set  != 4'd0)  && (mon_set  <= MON_DEC)
               && (week_set != 3'd0)
               && (day_set  != 5'd0)  && (day_set  <= set_days)
               && (hour_set <  5'd24) && (min_set  <  6'd60) && (sec_set < 6'd60);

  // c_<field> means "<field> receives a carry from the field below it".
  always_comb begin
    c_min  = (sec == 6'd59);
    c_hour = c_min  && (min  == 6'd59);
    c_day  = c_hour && (hour == 5'd23);
    c_mon  = c_day  && (day  >= cur_days);
    c_year = c_mon  && (mon  == MON_DEC);

    sec_n  = c_min  ? 6'd0    : sec + 6'd1;
    min_n  = c_hour ? 6'd0    : (c_min  ? min  + 6'd1 : min);
    hour_n = c_day  ? 5'd0    : (c_hour ? hour + 5'd1 : hour);
    day_n  = c_mon  ? 5'd1    : (c_day  ? day  + 5'd1 : day);
    mon_n  = c_year ? MON_JAN : (c_mon  ? mon  + 4'd1 : mon);
    week_n = week;
    if (c_day)
      week_n = (week == WK_SUN) ? WK_MON : week + 3'd1;
    year_n = year;
    if (c_year)
      year_n = (year == Y_MAX) ? Y_MIN : year + 1'b1;

    alarm_hit = alarm_en && c_min && (hour_n == alarm_hour) && (min_n == alarm_min);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      year       <= Y_RST;
      mon        <= MON_JAN;
      week       <= W_RST;
      day        <= 5'd1;
      hour       <= '0;
      min        <= '0;
      sec        <= '0;
      year_carry <= 1'b0;
      mon_carry  <= 1'b0;
      day_carry  <= 1'b0;
      hour_carry <= 1'b0;
      min_carry  <= 1'b0;
      set_err    <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      {year_carry, mon_carry, day_carry, hour_carry, min_carry} <= '0;
      set_err <= 1'b0;
      alarm   <= 1'b0;
      if (time_set && set_ok) begin
        // A valid load restarts the second and swallows any coincident tick.
        cnt  <= '0;
        year <= year_set;
        mon  <= mon_set;
        week <= week_set;
        day  <= day_set;
        hour <= hour_set;
        min  <= min_set;
        sec  <= sec_set;
      end else begin
        if (run)
          cnt <= tick ? '0 : cnt + 1'b1;
        if (time_set) begin
          set_err <= 1'b1;
        end else if (tick) begin
          year <= year_n;
          mon  <= mon_n;
          week <= week_n;
          day  <= day_n;
          hour <= hour_n;
          min  <= min_n;
          sec  <= sec_n;
          {year_carry, mon_carry, day_carry, hour_carry, min_carry} <=
            {c_year, c_mon, c_day, c_hour, c_min};
          alarm <= alarm_hit;
        end
      end
    end
  end

endmodule
